// File: rtl/his_builder_fsm_pkg.sv
// rtl/his_builder_fsm_pkg.sv - shared sizes and state type for the per-pixel histogram peak builder
package his_builder_fsm_pkg;

    localparam int NP                = 10;
    localparam int HB                = 3;
    localparam int NBINS             = 1 << HB;
    localparam int PIXEL_NUM_PER_RAM = 3;
    localparam int ACQ_NUM           = 2;
    localparam int CW                = $clog2(ACQ_NUM + 1);
    localparam int PW                = (PIXEL_NUM_PER_RAM > 1) ? $clog2(PIXEL_NUM_PER_RAM) : 1;
    localparam int AW                = (ACQ_NUM > 1) ? $clog2(ACQ_NUM) : 1;

    typedef enum logic [1:0] {
        ST_ACCUM  = 2'd0,
        ST_PEAK   = 2'd1,
        ST_UPDATE = 2'd2
    } state_t;

endpackage

// File: rtl/his_peak_finder.sv
// rtl/his_peak_finder.sv - running max/argmax over one pixel's histogram, one bin per cycle
module his_peak_finder
    import his_builder_fsm_pkg::*;
(
    input  logic          clk,
    input  logic          res,
    input  logic          i_en,
    input  logic [HB-1:0] i_bin,
    input  logic [CW-1:0] i_count,
    output logic [HB-1:0] o_max_bin
);

    logic [CW-1:0] r_max_cnt;
    logic [HB-1:0] r_max_bin;

    // Bin 0 restarts the scan; strict compare keeps the lower bin on ties.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_max_cnt <= '0;
            r_max_bin <= '0;
        end else if (i_en) begin
            if (i_bin == '0) begin
                r_max_cnt <= i_count;
                r_max_bin <= '0;
            end else if (i_count > r_max_cnt) begin
                r_max_cnt <= i_count;
                r_max_bin <= i_bin;
            end
        end
    end

    assign o_max_bin = r_max_bin;

endmodule

// File: rtl/his_builder_fsm.sv
// rtl/his_builder_fsm.sv - per-pixel ToF histogram accumulate/peak/update FSM (option: HIS_ZERO_REJECT_EN)
module his_builder_fsm
    import his_builder_fsm_pkg::*;
(
    input  logic          clk,
    input  logic          res,
    input  logic          wrEn,
    input  logic [NP-1:0] data,
    output logic [NP-1:0] peakResult [PIXEL_NUM_PER_RAM],
    output logic          peakValid
);

    state_t        r_state;
    logic [CW-1:0] r_hist [PIXEL_NUM_PER_RAM][NBINS];
    logic [PW-1:0] r_pix_idx;
    logic [AW-1:0] r_acq_idx;
    logic [HB-1:0] r_scan_bin;

    logic [HB-1:0] w_sample_bin;
    logic          w_count_en;
    logic          w_last_pix;
    logic          w_last_acq;
    logic [HB-1:0] w_max_bin  [PIXEL_NUM_PER_RAM];
    logic [CW-1:0] w_scan_cnt [PIXEL_NUM_PER_RAM];

    assign w_sample_bin = data[NP-1:NP-HB];
    assign w_last_pix   = (r_pix_idx == PW'(PIXEL_NUM_PER_RAM - 1));
    assign w_last_acq   = (r_acq_idx == AW'(ACQ_NUM - 1));

`ifdef HIS_ZERO_REJECT_EN
    // data==0 marks "no photon": the slot advances but no bin is counted.
    assign w_count_en = (data != '0);
`else
    logic w_unused_lsbs;
    assign w_unused_lsbs = ^data[NP-HB-1:0];
    assign w_count_en    = 1'b1;
`endif

    genvar g;
    generate
        for (g = 0; g < PIXEL_NUM_PER_RAM; g++) begin : g_pix
            assign w_scan_cnt[g] = r_hist[g][r_scan_bin];

            his_peak_finder u_peak (
                .clk       (clk),
                .res       (res),
                .i_en      (r_state == ST_PEAK),
                .i_bin     (r_scan_bin),
                .i_count   (w_scan_cnt[g]),
                .o_max_bin (w_max_bin[g])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_state    <= ST_ACCUM;
            r_pix_idx  <= '0;
            r_acq_idx  <= '0;
            r_scan_bin <= '0;
            peakValid  <= 1'b0;
            for (int p = 0; p < PIXEL_NUM_PER_RAM; p++) begin
                peakResult[p] <= '0;
                for (int b = 0; b < NBINS; b++) r_hist[p][b] <= '0;
            end
        end else begin
            peakValid <= 1'b0;
            case (r_state)
                ST_ACCUM: begin
                    if (wrEn) begin
                        if (w_count_en)
                            r_hist[r_pix_idx][w_sample_bin] <= r_hist[r_pix_idx][w_sample_bin] + CW'(1);
                        if (w_last_pix) begin
                            r_pix_idx <= '0;
                            if (w_last_acq) begin
                                r_acq_idx  <= '0;
                                r_scan_bin <= '0;
                                r_state    <= ST_PEAK;
                            end else begin
                                r_acq_idx <= r_acq_idx + AW'(1);
                            end
                        end else begin
                            r_pix_idx <= r_pix_idx + PW'(1);
                        end
                    end
                end
                ST_PEAK: begin
                    r_scan_bin <= r_scan_bin + HB'(1);
                    if (r_scan_bin == HB'(NBINS - 1)) r_state <= ST_UPDATE;
                end
                ST_UPDATE: begin
                    peakValid  <= 1'b1;
                    r_pix_idx  <= '0;
                    r_acq_idx  <= '0;
                    r_scan_bin <= '0;
                    r_state    <= ST_ACCUM;
                    for (int p = 0; p < PIXEL_NUM_PER_RAM; p++) begin
                        peakResult[p] <= {w_max_bin[p], {(NP-HB){1'b0}}};
                        for (int b = 0; b < NBINS; b++) r_hist[p][b] <= '0;
                    end
                end
                default: r_state <= ST_ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_his_builder_fsm.sv
// tb/tb_his_builder_fsm.sv - directed self-checking bench for his_builder_fsm
module tb_his_builder_fsm;
    import his_builder_fsm_pkg::*;

    typedef int frame_t [6];

    logic          clk;
    logic          res;
    logic          wrEn;
    logic [NP-1:0] data;
    logic [NP-1:0] peak_result [PIXEL_NUM_PER_RAM];
    logic          peak_valid;

    int n_checks = 0;
    int n_pass   = 0;

    his_builder_fsm dut (
        .clk        (clk),
        .res        (res),
        .wrEn       (wrEn),
        .data       (data),
        .peakResult (peak_result),
        .peakValid  (peak_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic push(input int d);
        wrEn = 1'b1;
        data = NP'(d);
        @(negedge clk);
    endtask

    task automatic send_frame(input frame_t f, input int gap_after);
        for (int i = 0; i < 6; i++) begin
            push(f[i]);
            if (i == gap_after) begin
                wrEn = 1'b0;
                repeat (5) @(negedge clk);
            end
        end
    endtask

    // Caller chooses what wrEn/data do during the scan; valid lands 9 edges after the last accept.
    task automatic wait_result(input string tag, input int e0, input int e1, input int e2);
        int n;
        n = 0;
        while (!peak_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        wrEn = 1'b0;
        check({tag, "_latency"}, n, 9);
        check({tag, "_p0"}, int'(peak_result[0]), e0);
        check({tag, "_p1"}, int'(peak_result[1]), e1);
        check({tag, "_p2"}, int'(peak_result[2]), e2);
        @(negedge clk);
        check({tag, "_valid_pulse_end"}, int'(peak_valid), 0);
    endtask

    frame_t fa = '{108, 511, 1022, 1022, 200, 90};
    frame_t fb = '{300, 500, 50, 1000, 48, 90};
    frame_t fc = '{1000, 400, 130, 1023, 450, 200};
    frame_t fd = '{1023, 0, 640, 0, 0, 650};
    int exp_zero;

    initial begin
        res  = 1'b1;
        wrEn = 1'b0;
        data = '0;
        repeat (2) @(negedge clk);
        check("rst_p0", int'(peak_result[0]), 0);
        check("rst_p1", int'(peak_result[1]), 0);
        check("rst_p2", int'(peak_result[2]), 0);
        check("rst_valid", int'(peak_valid), 0);
        res = 1'b0;
        @(negedge clk);

        send_frame(fa, -1);
        wrEn = 1'b0;
        wait_result("frame_a", 0, 128, 0);

        send_frame(fb, -1);
        wrEn = 1'b0;
        wait_result("frame_b", 256, 0, 0);
        repeat (5) @(negedge clk);
        check("hold_p0", int'(peak_result[0]), 256);
        check("hold_valid", int'(peak_valid), 0);

        send_frame(fc, 2);
        wrEn = 1'b0;
        wait_result("gap_c", 896, 384, 128);

        for (int i = 0; i < 4; i++) push(fc[i]);
        wrEn = 1'b0;
        #2 res = 1'b1;
        #1;
        check("midrst_p0", int'(peak_result[0]), 0);
        check("midrst_p1", int'(peak_result[1]), 0);
        check("midrst_valid", int'(peak_valid), 0);
        @(negedge clk);
        res = 1'b0;
        @(negedge clk);
        send_frame(fa, -1);
        wrEn = 1'b0;
        wait_result("post_rst_a", 0, 128, 0);

        send_frame(fc, -1);
        wrEn = 1'b1;
        data = NP'(1023);
        wait_result("drop_c", 896, 384, 128);
        send_frame(fb, -1);
        wrEn = 1'b0;
        wait_result("after_drop_b", 256, 0, 0);

`ifdef HIS_ZERO_REJECT_EN
        exp_zero = 896;
`else
        exp_zero = 0;
`endif
        send_frame(fd, -1);
        wrEn = 1'b0;
        wait_result("zero_d", exp_zero, 0, 640);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
